// File: rtl/bomb_controller.sv
// Per-player bomb unit: arms a bomb at the player's cell on a place press, runs the
// fuse in game seconds, emits a one-cycle explosion pulse, then enforces a cooldown.
module bomb_controller #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int FUSE_SEC      = 3,
    parameter int COOLDOWN_SEC  = 2,
    parameter int POS_W         = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             gameRun,
    input  logic             place,
    input  logic             stunned,
    input  logic [POS_W-1:0] playerPosX,
    input  logic [POS_W-1:0] playerPosY,
    output logic [POS_W-1:0] bombPosX,
    output logic [POS_W-1:0] bombPosY,
    output logic             bombActive,
    output logic             bombExploded,
    output logic             ready,
    output logic [3:0]       fuseSecLeft,
    output logic [1:0]       state_dbg
);

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]    FUSE_M1  = 4'(FUSE_SEC - 1);
    localparam logic [3:0]    COOL_M1  = 4'((COOLDOWN_SEC > 0) ? COOLDOWN_SEC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        EXPLODE  = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   tick_cnt, tick_nx;
    logic [3:0]      sec_cnt, sec_nx;
    logic [POS_W-1:0] pos_x_nx, pos_y_nx;
    logic            place_d;
    logic            place_edge;

    assign place_edge = place & ~place_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            tick_cnt <= '0;
            sec_cnt  <= '0;
            bombPosX <= '0;
            bombPosY <= '0;
            place_d  <= 1'b0;
        end else begin
            state    <= state_nx;
            tick_cnt <= tick_nx;
            sec_cnt  <= sec_nx;
            bombPosX <= pos_x_nx;
            bombPosY <= pos_y_nx;
            place_d  <= place;
        end
    end

    // ARMED and COOLDOWN share the same seconds countdown; only the exit differs.
    always_comb begin
        state_nx = state;
        tick_nx  = tick_cnt;
        sec_nx   = sec_cnt;
        pos_x_nx = bombPosX;
        pos_y_nx = bombPosY;
        if (!gameRun) begin
            state_nx = IDLE;
            tick_nx  = '0;
            sec_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (place_edge && !stunned) begin
                        pos_x_nx = playerPosX;
                        pos_y_nx = playerPosY;
                        tick_nx  = TICK_MAX;
                        sec_nx   = FUSE_M1;
                        state_nx = ARMED;
                    end
                end
                ARMED, COOLDOWN: begin
                    if (tick_cnt != '0) begin
                        tick_nx = tick_cnt - TW'(1);
                    end else if (sec_cnt != 4'd0) begin
                        sec_nx  = sec_cnt - 4'd1;
                        tick_nx = TICK_MAX;
                    end else begin
                        state_nx = (state == ARMED) ? EXPLODE : IDLE;
                    end
                end
                EXPLODE: begin
                    if (COOLDOWN_SEC == 0) begin
                        state_nx = IDLE;
                        tick_nx  = '0;
                        sec_nx   = '0;
                    end else begin
                        state_nx = COOLDOWN;
                        tick_nx  = TICK_MAX;
                        sec_nx   = COOL_M1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    tick_nx  = '0;
                    sec_nx   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only, never from inputs.
    assign ready        = (state == IDLE);
    assign bombActive   = (state == ARMED) || (state == EXPLODE);
    assign bombExploded = (state == EXPLODE);
    assign fuseSecLeft  = (state == ARMED) ? sec_cnt + 4'd1 : 4'd0;
    assign state_dbg    = state;

endmodule

// File: tb/tb_bomb_controller.sv
// Bench for bomb_controller: one instance with a 4-tick/2s fuse/1s cooldown and
// one with 1 tick per second and no cooldown.
module tb_bomb_controller;

    localparam int POS_W = 6;
    localparam int TPS   = 4;
    localparam int FUSE  = 2;
    localparam int W     = 2 * POS_W;

    logic             clk;
    logic             resetn;
    logic             gameRun;
    logic             place;
    logic             place2;
    logic             stunned;
    logic [POS_W-1:0] pos_x, pos_y;

    logic [POS_W-1:0] bomb_x, bomb_y, bomb_x2, bomb_y2;
    logic             active, exploded, rdy, active2, exploded2, rdy2;
    logic [3:0]       fsl, fsl2;
    logic [1:0]       st, st2;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];

    bomb_controller #(.TICKS_PER_SEC(TPS), .FUSE_SEC(FUSE), .COOLDOWN_SEC(1), .POS_W(POS_W)) dut (
        .clk(clk), .resetn(resetn), .gameRun(gameRun), .place(place), .stunned(stunned),
        .playerPosX(pos_x), .playerPosY(pos_y), .bombPosX(bomb_x), .bombPosY(bomb_y),
        .bombActive(active), .bombExploded(exploded), .ready(rdy), .fuseSecLeft(fsl),
        .state_dbg(st)
    );

    bomb_controller #(.TICKS_PER_SEC(1), .FUSE_SEC(3), .COOLDOWN_SEC(0), .POS_W(POS_W)) dut0 (
        .clk(clk), .resetn(resetn), .gameRun(gameRun), .place(place2), .stunned(stunned),
        .playerPosX(pos_x), .playerPosY(pos_y), .bombPosX(bomb_x2), .bombPosY(bomb_y2),
        .bombActive(active2), .bombExploded(exploded2), .ready(rdy2), .fuseSecLeft(fsl2),
        .state_dbg(st2)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle press; when expect_pulse is set the explosion is queued for the monitor.
    task automatic arm(input logic [POS_W-1:0] x, input logic [POS_W-1:0] y, input bit expect_pulse);
        pos_x = x;
        pos_y = y;
        place = 1'b1;
        if (expect_pulse) begin
            exp_q.push_back({x, y});
            exp_cyc_q.push_back(cyc + 1 + FUSE * TPS);
        end
        step(1);
        place = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!rdy && n < 50) begin
            step(1);
            n++;
        end
        check(tag, 32'(rdy), 32'd1);
    endtask

    // Scoreboard: every explosion pulse must match the oldest queued placement.
    always @(negedge clk) begin
        if (resetn && exploded) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                logic [W-1:0] e;
                int           ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("pulse_pos", 32'({bomb_x, bomb_y}), 32'(e));
                check("pulse_cycle", 32'(cyc), 32'(ec));
            end
        end
    end

    initial begin
        resetn  = 1'b0;
        gameRun = 1'b1;
        place   = 1'b0;
        place2  = 1'b0;
        stunned = 1'b0;
        pos_x   = '0;
        pos_y   = '0;
        step(3);
        check("rst_ready", 32'(rdy), 32'd1);
        check("rst_active", 32'(active), 32'd0);
        check("rst_fsl", 32'(fsl), 32'd0);
        check("rst_pos", 32'({bomb_x, bomb_y}), 32'd0);
        resetn = 1'b1;
        step(2);

        // 1 tick/s, no cooldown: 3 ARMED cycles, one EXPLODE, straight back to IDLE
        pos_x  = 6'd9;
        pos_y  = 6'd4;
        place2 = 1'b1;
        step(1);
        place2 = 1'b0;
        check("t1s_fsl3", 32'(fsl2), 32'd3);
        step(1);
        check("t1s_fsl2", 32'(fsl2), 32'd2);
        step(1);
        check("t1s_fsl1", 32'(fsl2), 32'd1);
        step(1);
        check("t1s_expl", 32'(exploded2), 32'd1);
        check("t1s_pos", 32'({bomb_x2, bomb_y2}), 32'({6'd9, 6'd4}));
        step(1);
        check("t1s_idle", 32'(rdy2), 32'd1);
        check("t1s_nopulse", 32'(exploded2), 32'd0);
        step(2);

        // Basic fuse / explosion / cooldown timeline
        arm(6'd5, 6'd7, 1'b1);
        check("arm_active", 32'(active), 32'd1);
        check("arm_ready", 32'(rdy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("fsl_two", 32'(fsl), 32'd2);
            step(1);
        end
        for (int i = 0; i < 4; i++) begin
            check("fsl_one", 32'(fsl), 32'd1);
            step(1);
        end
        check("expl_pulse", 32'(exploded), 32'd1);
        check("expl_active", 32'(active), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("cool_ready", 32'(rdy), 32'd0);
            check("cool_pulse", 32'(exploded), 32'd0);
        end
        step(1);
        check("cool_done", 32'(rdy), 32'd1);
        check("cool_pos_held", 32'({bomb_x, bomb_y}), 32'({6'd5, 6'd7}));

        // Held button arms exactly once
        pos_x = 6'd2;
        pos_y = 6'd3;
        place = 1'b1;
        exp_q.push_back({6'd2, 6'd3});
        exp_cyc_q.push_back(cyc + 1 + FUSE * TPS);
        step(40);
        check("held_idle", 32'(rdy), 32'd1);
        place = 1'b0;
        step(2);

        // Stunned press is dropped; releasing stun while held does not arm
        stunned = 1'b1;
        place   = 1'b1;
        step(1);
        check("stun_ready", 32'(rdy), 32'd1);
        check("stun_fsl", 32'(fsl), 32'd0);
        step(1);
        stunned = 1'b0;
        step(3);
        check("stun_release", 32'(rdy), 32'd1);
        place = 1'b0;
        step(1);

        // Position latched on the arming edge; press during ARMED ignored
        arm(6'd10, 6'd3, 1'b1);
        pos_x = 6'd11;
        step(2);
        place = 1'b1;
        step(1);
        place = 1'b0;
        wait_ready("move_back_idle");
        step(2);

        // Abort on the expiry cycle: no pulse
        arm(6'd1, 6'd2, 1'b0);
        step(7);
        gameRun = 1'b0;
        step(1);
        check("abort_ready", 32'(rdy), 32'd1);
        check("abort_fsl", 32'(fsl), 32'd0);
        check("abort_active", 32'(active), 32'd0);
        check("abort_pos", 32'({bomb_x, bomb_y}), 32'({6'd1, 6'd2}));
        gameRun = 1'b1;
        step(3);

        // Asynchronous reset mid-ARMED
        arm(6'd20, 6'd21, 1'b0);
        step(3);
        #2 resetn = 1'b0;
        #1;
        check("areset_ready", 32'(rdy), 32'd1);
        check("areset_active", 32'(active), 32'd0);
        check("areset_fsl", 32'(fsl), 32'd0);
        check("areset_pos", 32'({bomb_x, bomb_y}), 32'd0);
        step(2);
        resetn = 1'b1;
        step(20);
        check("post_reset_ready", 32'(rdy), 32'd1);

        check("pending_pulses", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
